store_data_narrower: RTL and testbench

- Write-side counterpart of the 16→32 immediate/load sign extension in the MIPS datapath.
- Takes a 32-bit register value plus a byte address and access size (SB/SH/SW), and narrows it to the selected lane(s). Produces word-aligned address, replicated write data and byte enables for data memory.
- Sits between the EX/MEM pipeline register and the data memory port. Uses valid/ready handshakes and a 2-entry skid buffer so memory back-pressure does not break the datapath timing.
- Flags misaligned or illegal stores instead of writing them.

---
 rtl/store_data_narrower.sv | 186 ++++++++++++++++++
 tb/tb_store_data_narrower.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_data_narrower.sv
// rtl/store_data_narrower.sv - narrows a register value to SB/SH/SW lanes for data memory
// Two-entry skid buffer between EX/MEM and the memory port; bad stores are counted, never written.
module store_data_narrower #(
    parameter int BIG_ENDIAN = 0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    input  logic [31:0]          in_addr,
    input  logic [1:0]           in_size,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_addr,
    output logic [31:0]          out_wdata,
    output logic [3:0]           out_be,
    output logic                 err_valid,
    output logic [31:0]          err_addr,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t state;
    state_t state_next;

    logic [31:0] fmt_addr;
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_be_le;
    logic [3:0]  fmt_be;
    logic        fmt_err;

    logic        accept;
    logic        push;
    logic        pop;
    logic        err_in;

    logic        load_head_new;
    logic        load_head_second;
    logic        load_second;

    logic [31:0] second_addr;
    logic [31:0] second_wdata;
    logic [3:0]  second_be;

    // Request formatting: lane replication and little-endian byte enables.
    always_comb begin
        fmt_addr  = {in_addr[31:2], 2'b00};
        fmt_wdata = in_data;
        fmt_be_le = 4'b0000;
        fmt_err   = 1'b0;
        case (in_size)
            SIZE_BYTE: begin
                fmt_wdata = {4{in_data[7:0]}};
                fmt_be_le = 4'b0001 << in_addr[1:0];
            end
            SIZE_HALF: begin
                fmt_wdata = {2{in_data[15:0]}};
                fmt_be_le = in_addr[1] ? 4'b1100 : 4'b0011;
                fmt_err   = in_addr[0];
            end
            SIZE_WORD: begin
                fmt_wdata = in_data;
                fmt_be_le = 4'b1111;
                fmt_err   = (in_addr[1:0] != 2'b00);
            end
            default: begin
                fmt_err   = 1'b1;
            end
        endcase
    end

    // Big-endian only mirrors the lane enables; the replicated data already covers every lane.
    assign fmt_be = (BIG_ENDIAN != 0) ? {fmt_be_le[0], fmt_be_le[1], fmt_be_le[2], fmt_be_le[3]}
                                      : fmt_be_le;

    assign accept = in_valid && in_ready;
    assign push   = accept && !fmt_err;
    assign err_in = accept && fmt_err;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: begin
                if (push) state_next = ST_ONE;
            end
            ST_ONE: begin
                if (push && !pop)      state_next = ST_TWO;
                else if (pop && !push) state_next = ST_EMPTY;
            end
            ST_TWO: begin
                if (pop) state_next = ST_ONE;
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid        = (state != ST_EMPTY);
        load_head_new    = 1'b0;
        load_head_second = 1'b0;
        load_second      = 1'b0;
        case (state)
            ST_EMPTY: load_head_new = push;
            ST_ONE: begin
                load_head_new = push && pop;
                load_second   = push && !pop;
            end
            ST_TWO: load_head_second = pop;
            default: ;
        endcase
    end

    // in_ready is registered so it stays off the memory-side combinational path.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= (state_next != ST_TWO);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_addr  <= 32'd0;
            out_wdata <= 32'd0;
            out_be    <= 4'd0;
        end else if (load_head_new) begin
            out_addr  <= fmt_addr;
            out_wdata <= fmt_wdata;
            out_be    <= fmt_be;
        end else if (load_head_second) begin
            out_addr  <= second_addr;
            out_wdata <= second_wdata;
            out_be    <= second_be;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            second_addr  <= 32'd0;
            second_wdata <= 32'd0;
            second_be    <= 4'd0;
        end else if (load_second) begin
            second_addr  <= fmt_addr;
            second_wdata <= fmt_wdata;
            second_be    <= fmt_be;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_valid <= 1'b0;
            err_addr  <= 32'd0;
            err_count <= '0;
        end else begin
            err_valid <= err_in;
            if (err_in) begin
                err_addr <= in_addr;
                if (err_count != {ERR_CNT_W{1'b1}}) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_store_data_narrower.sv
// tb/tb_store_data_narrower.sv - directed bench for store_data_narrower
// Little-endian/8-bit counter and big-endian/2-bit counter instances share one stimulus.
module tb_store_data_narrower;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic [31:0] in_addr;
    logic [1:0]  in_size;
    logic        out_ready;

    logic        in_ready, out_valid, err_valid;
    logic [31:0] out_addr, out_wdata, err_addr;
    logic [3:0]  out_be;
    logic [7:0]  err_count;

    logic        b_in_ready, b_out_valid, b_err_valid;
    logic [31:0] b_out_addr, b_out_wdata, b_err_addr;
    logic [3:0]  b_out_be;
    logic [1:0]  b_err_count;

    int checks;
    int failures;

    store_data_narrower #(.BIG_ENDIAN(0), .ERR_CNT_W(8)) dut_le (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_addr(in_addr), .in_size(in_size),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_wdata(out_wdata), .out_be(out_be),
        .err_valid(err_valid), .err_addr(err_addr), .err_count(err_count)
    );

    store_data_narrower #(.BIG_ENDIAN(1), .ERR_CNT_W(2)) dut_be (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_addr(in_addr), .in_size(in_size),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_addr(b_out_addr), .out_wdata(b_out_wdata), .out_be(b_out_be),
        .err_valid(b_err_valid), .err_addr(b_err_addr), .err_count(b_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] a,
                         input logic [1:0] s);
        in_valid = v;
        in_data  = d;
        in_addr  = a;
        in_size  = s;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 2'b00);
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++;
        if (out_valid !== 1'b0 || out_be !== 4'd0 || out_addr !== 32'd0 || out_wdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_out got=%b/%h/%h/%h exp=0/0/0/0", out_valid, out_be, out_addr, out_wdata);
        end
        checks++;
        if (err_count !== 8'd0 || err_valid !== 1'b0 || err_addr !== 32'd0) begin
            failures++;
            $display("FAIL reset_err got=%h/%b/%h exp=0/0/0", err_count, err_valid, err_addr);
        end
        reset = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_in_ready got=%b/%b exp=1/1", in_ready, b_in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_byte();
        out_ready = 1'b1;
        drive(1'b1, 32'h12345678, 32'h00001003, 2'b00);
        step();
        drive(1'b0, 32'd0, 32'd0, 2'b00);
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 32'h00001000 || out_wdata !== 32'h78787878) begin
            failures++;
            $display("FAIL sb_data got=%b/%h/%h exp=1/00001000/78787878", out_valid, out_addr, out_wdata);
        end
        checks++;
        if (out_be !== 4'b1000) begin failures++; $display("FAIL sb_be_le got=%b exp=1000", out_be); end
        checks++;
        if (b_out_be !== 4'b0001) begin failures++; $display("FAIL sb_be_be got=%b exp=0001", b_out_be); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL sb_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(1'b1, 32'hAABBCCDD, 32'h00002002, 2'b01);
        step();
        drive(1'b1, 32'hDEADBEEF, 32'h00002004, 2'b10);
        checks++;
        if (out_valid !== 1'b1 || out_wdata !== 32'hCCDDCCDD || out_be !== 4'b1100 || out_addr !== 32'h00002000) begin
            failures++;
            $display("FAIL sh_out got=%b/%h/%b/%h exp=1/ccddccdd/1100/00002000", out_valid, out_wdata, out_be, out_addr);
        end
        checks++;
        if (b_out_be !== 4'b0011) begin failures++; $display("FAIL sh_be_be got=%b exp=0011", b_out_be); end
        step();
        drive(1'b0, 32'd0, 32'd0, 2'b00);
        checks++;
        if (out_valid !== 1'b1 || out_wdata !== 32'hDEADBEEF || out_be !== 4'b1111 || out_addr !== 32'h00002004) begin
            failures++;
            $display("FAIL sw_out got=%b/%h/%b/%h exp=1/deadbeef/1111/00002004", out_valid, out_wdata, out_be, out_addr);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'hA0A0A0A0, 32'h00004000, 2'b10);
        step();
        drive(1'b1, 32'hA1A1A1A1, 32'h00004004, 2'b10);
        checks++;
        if (in_ready !== 1'b1 || out_wdata !== 32'hA0A0A0A0) begin
            failures++;
            $display("FAIL bp_first got=%b/%h exp=1/a0a0a0a0", in_ready, out_wdata);
        end
        step();
        drive(1'b1, 32'hA2A2A2A2, 32'h00004008, 2'b10);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_wdata !== 32'hA0A0A0A0) begin
            failures++;
            $display("FAIL bp_full got=%b/%b/%h exp=0/1/a0a0a0a0", in_ready, out_valid, out_wdata);
        end
        step();
        checks++;
        if (in_ready !== 1'b0 || out_wdata !== 32'hA0A0A0A0 || out_addr !== 32'h00004000) begin
            failures++;
            $display("FAIL bp_hold got=%b/%h/%h exp=0/a0a0a0a0/00004000", in_ready, out_wdata, out_addr);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_wdata !== 32'hA1A1A1A1 || out_addr !== 32'h00004004) begin
            failures++;
            $display("FAIL bp_second got=%b/%b/%h/%h exp=1/1/a1a1a1a1/00004004", in_ready, out_valid, out_wdata, out_addr);
        end
        step();
        drive(1'b0, 32'd0, 32'd0, 2'b00);
        checks++;
        if (out_valid !== 1'b1 || out_wdata !== 32'hA2A2A2A2 || out_addr !== 32'h00004008) begin
            failures++;
            $display("FAIL bp_third got=%b/%h/%h exp=1/a2a2a2a2/00004008", out_valid, out_wdata, out_addr);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [5];
        logic [1:0]  sizes [5];
        addrs = '{32'h00003001, 32'h00003005, 32'h00003008, 32'h00003002, 32'h00003003};
        sizes = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hFFFFFFFF, addrs[i], sizes[i]);
            step();
            checks++;
            if (err_valid !== 1'b1 || err_addr !== addrs[i] || err_count !== 8'(i + 1)) begin
                failures++;
                $display("FAIL err_pulse%0d got=%b/%h/%0d exp=1/%h/%0d", i, err_valid, err_addr, err_count, addrs[i], i + 1);
            end
            checks++;
            if (out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL err_no_out%0d got=%b/%b exp=0/0", i, out_valid, b_out_valid);
            end
            if (i == 2) begin
                checks++;
                if (b_err_count !== 2'd3) begin failures++; $display("FAIL err_cnt3_w2 got=%0d exp=3", b_err_count); end
            end
        end
        drive(1'b0, 32'd0, 32'd0, 2'b00);
        step();
        checks++;
        if (err_valid !== 1'b0 || err_count !== 8'd5 || err_addr !== 32'h00003003) begin
            failures++;
            $display("FAIL err_end got=%b/%0d/%h exp=0/5/00003003", err_valid, err_count, err_addr);
        end
        checks++;
        if (b_err_count !== 2'd3) begin failures++; $display("FAIL err_sat_w2 got=%0d exp=3", b_err_count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 32'h55555555, 32'h00005000, 2'b10);
        step();
        drive(1'b1, 32'h66666666, 32'h00005004, 2'b10);
        step();
        drive(1'b0, 32'd0, 32'd0, 2'b00);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rm_two got=%b/%b exp=0/1", in_ready, out_valid);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_be !== 4'd0) begin
            failures++;
            $display("FAIL rm_flush got=%b/%b exp=0/0000", out_valid, out_be);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rm_ghost%0d got=%b/%b exp=0/0", i, out_valid, b_out_valid);
            end
        end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", in_ready); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 2'b00);
        test_reset();
        test_byte();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
